// File: rtl/dp_share_arbiter.sv
// dp_share_arbiter
// Round-robin front end for a shared threshold/capture datapath. One request
// is accepted at a time. The arbiter drives the datapath operand and waits a
// fixed LAT cycles. It then presents the captured result, tagged with the
// requester index, on a valid/ready response channel.
module dp_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int LAT     = 1,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]         dp_data_in,
   input  logic [WIDTH-1:0]         dp_data_out,
   output logic                     rsp_valid,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [IDW-1:0]           rsp_id,
   input  logic                     rsp_ready,
   output logic                     busy,
   output logic [15:0]              done_cnt
);

   // Latency counter is sized for the largest supported LAT (7).
   localparam int CW = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDW-1:0]    ptr;
   logic [CW-1:0]     wait_cnt;
   logic [IDW-1:0]    grant_idx;
   logic              grant_found;
   logic              accept;
   logic              rsp_done;
   logic              wait_last;
   logic [IDW-1:0]    ptr_nxt;
   logic [WIDTH-1:0]  req_word [NUM_REQ];

   // Index of the k-th requester visited when scanning upward from base with wrap.
   function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IDW'(sum);
   endfunction

   // Split the flat request bus into one word per requester.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_word[i] = req_data[i*WIDTH +: WIDTH];
      end
   end

   // Round-robin search: first valid requester at or after ptr wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && req_valid[rr_index(ptr, k)]) begin
            grant_found = 1'b1;
            grant_idx   = rr_index(ptr, k);
         end
      end
   end

   // Grant is offered only in IDLE and never while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (reset && (state == IDLE) && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign accept    = reset && (state == IDLE) && grant_found;
   assign rsp_valid = (state == RESP);
   assign rsp_done  = rsp_valid && rsp_ready;
   assign wait_last = (wait_cnt == CW'(1));
   assign busy      = (state != IDLE);
   assign ptr_nxt   = (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;

   // Next-state selection for the request/issue/wait/respond sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = ISSUE;
         ISSUE:                  state_nxt = WAIT;
         WAIT:    if (wait_last) state_nxt = RESP;
         RESP:    if (rsp_done)  state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand launch, latency count, result capture, pointer and completion count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr        <= '0;
         wait_cnt   <= '0;
         dp_data_in <= '0;
         rsp_data   <= '0;
         rsp_id     <= '0;
         done_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rsp_id     <= grant_idx;
                  dp_data_in <= req_word[grant_idx];
               end
            end
            ISSUE: begin
               wait_cnt <= CW'(LAT);
            end
            WAIT: begin
               wait_cnt <= wait_cnt - CW'(1);
               if (wait_last) begin
                  rsp_data <= dp_data_out;
               end
            end
            RESP: begin
               if (rsp_done) begin
                  done_cnt <= done_cnt + 16'd1;
                  ptr      <= ptr_nxt;
               end
            end
            default: begin
               wait_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/dp_share_arbiter.md
Name: dp_share_arbiter

Overview:
Round-robin arbiter that shares one 8-bit threshold/capture datapath among NUM_REQ requesters. The datapath passes values strictly greater than THRESH, zeroes all others, and registers its output. The arbiter accepts one request at a time over a valid/ready handshake and drives the datapath. It waits the datapath's fixed latency, then returns the captured result with the requester ID on a valid/ready response channel. It sits between the requester-side logic and the datapath instance and is the only driver of the datapath input.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, data width of requests, datapath and response
LAT, 1, datapath latency in cycles from dp_data_in to a valid dp_data_out (1..7)
IDW, $clog2(NUM_REQ), width of requester ID

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_data  input  NUM_REQ*WIDTH  request data; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
dp_data_in  output  WIDTH  registered datapath operand
dp_data_out  input  WIDTH  datapath result
rsp_valid  output  1  response valid
rsp_data  output  WIDTH  captured datapath result
rsp_id  output  IDW  index of the requester that owns rsp_data
rsp_ready  input  1  response accept
busy  output  1  high in any state other than IDLE
done_cnt  output  16  count of completed responses; wraps 0xFFFF->0

Behaviour:
- Reset: a clk edge with reset==0 forces state=IDLE, ptr=0, dp_data_in=0, rsp_valid=0, rsp_data=0, rsp_id=0, done_cnt=0, wait counter=0. req_ready is 0 while reset==0. Any in-flight transaction is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: search req_valid starting at index ptr, ascending with wrap; the first set bit wins (g).
  - req_ready[g] is driven combinationally high in the same cycle. All other req_ready bits stay 0. req_ready is 0 in every other state.
  - On handshake (valid&ready): latch g into rsp_id and req_data slice g into dp_data_in. Next state is ISSUE.
  - No valid: stay in IDLE. dp_data_in holds its last value.
- ISSUE: one cycle. dp_data_in is stable and the datapath samples it at the end of this cycle. Load wait counter=LAT. Next state is WAIT.
- WAIT: decrement the counter each cycle. In the cycle where the counter==1, capture dp_data_out into rsp_data at the end of the cycle, then go to RESP.
- RESP: rsp_valid=1, with rsp_data and rsp_id held stable.
  - On rsp_valid&rsp_ready: rsp_valid goes to 0, done_cnt increments, ptr=(rsp_id+1) mod NUM_REQ, next state is IDLE.
  - rsp_ready low: stay in RESP indefinitely; no new grants.
- Latency: handshake in cycle 0 -> ISSUE in cycle 1 -> WAIT in cycles 2..1+LAT -> rsp_valid in cycle 2+LAT (cycle 3 for LAT=1).
- Throughput: a new grant is possible no earlier than the cycle after the response handshake. There is no bypass from RESP to grant. Minimum period is 4+LAT-1 cycles for a single stream.
- A request whose valid drops before grant is simply not served. Requesters must hold req_data stable while valid is high.
- rsp_ready high before rsp_valid has no effect.
- Round-robin fairness: a continuously valid requester waits at most NUM_REQ-1 transactions.

Test Plan:
- Threshold pass-through, LAT=1: req0 sends 0x81 -> rsp_data=0x81, rsp_id=0, rsp_valid in the 3rd cycle after handshake. req0 sends 0x80 -> rsp_data=0x00. req0 sends 0xFF -> 0xFF.
- Round robin: req0..3 all valid together with 0x90, 0x91, 0x92, 0x93 and rsp_ready tied high -> responses in id order 0,1,2,3 with matching data. A further req0 request then gets id 0 (ptr wraps). done_cnt=4 after the fourth response.
- Fairness from a non-zero ptr: after serving id 2, assert req1 and req3 simultaneously -> id 3 is served first, then id 1.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay stable and req_ready stays 0 throughout. Releasing rsp_ready completes exactly one response.
- Reset mid-operation: drive reset=0 for one edge during WAIT -> next cycle state is IDLE, rsp_valid=0, done_cnt=0, ptr=0, and no response for the dropped request. With req2 held valid, the next grant goes to req2.
- Single streaming requester: req2 held valid with 0xA5 -> granted every 4 cycles (LAT=1, rsp_ready high) with rsp_id=2 each time. Repeat to 0x10000 responses and check that done_cnt wraps to 0.
